// File: rtl/mem_port_arb_pkg.sv
// Shared definitions for the unified memory-port arbiter: FSM encoding,
// owner codes and the default watchdog limit.
package mem_port_arb_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_BUSY = 2'd1;
  localparam logic [1:0] ARB_DONE = 2'd2;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = ARB_IDLE,
    ST_BUSY = ARB_BUSY,
    ST_DONE = ARB_DONE
  } arb_state_e;

endpackage

// File: rtl/mem_port_arb_bus_wdog.sv
// Watchdog for bus transfers: counts enabled cycles since the last clear and
// flags expiry on the TIMEOUT-th enabled cycle. TIMEOUT=0 removes it.
module bus_wdog
  import mem_port_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  if (TIMEOUT == 0) begin : g_off
    assign o_expire = 1'b0;
  end else begin : g_on
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (i_clr) begin
        r_cnt <= '0;
      end else if (i_en) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign o_expire = i_en && (r_cnt == LAST);
  end

endmodule

// File: rtl/mem_port_arb.sv
// Arbiter sharing one memory port between IF and MEM: fixed MEM priority,
// IDLE/BUSY/DONE serialisation, per-stage stalls and a hung-transfer watchdog.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  output logic              if_stall_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_wsel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              mem_stall_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_wsel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ready_i,
  output logic              bus_err_o
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_owner;
  logic              r_we;
  logic [3:0]        r_wsel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_err;

  logic              w_busy;
  logic              w_done;
  logic              w_grant;
  logic              w_expire;
  logic              w_finish;
  logic [DATA_W-1:0] w_cap_data;

  assign w_busy     = (r_state == ST_BUSY);
  assign w_done     = (r_state == ST_DONE);
  assign w_grant    = (r_state == ST_IDLE) && (mem_req_i || if_req_i);
  assign w_finish   = w_busy && (bus_ready_i || w_expire);
  assign w_cap_data = bus_ready_i ? bus_rdata_i : '0;

  // Counter restarts on every BUSY entry; only unanswered BUSY cycles count.
  bus_wdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (!w_busy),
    .i_en     (w_busy && !bus_ready_i),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: the default assignment first means every path drives
  // w_state_nxt, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (mem_req_i || if_req_i) w_state_nxt = ST_BUSY;
      ST_BUSY: if (bus_ready_i || w_expire) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_IF;
      r_we        <= 1'b0;
      r_wsel      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_grant) begin
        // MEM holds the older instruction, so it always wins a tie.
        r_owner <= mem_req_i ? OWN_MEM : OWN_IF;
        r_addr  <= mem_req_i ? mem_addr_i : if_addr_i;
        r_we    <= mem_req_i && mem_we_i;
        r_wsel  <= (mem_req_i && mem_we_i) ? mem_wsel_i : 4'b0000;
        r_wdata <= mem_req_i ? mem_wdata_i : '0;
      end
      if (w_finish) begin
        if (r_owner == OWN_IF) begin
          r_if_rdata <= w_cap_data;
        end else if (!r_we) begin
          r_mem_rdata <= w_cap_data;
        end
      end
      if (w_expire) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus_req_o   = w_busy;
  assign bus_we_o    = r_we;
  assign bus_wsel_o  = r_wsel;
  assign bus_addr_o  = r_addr;
  assign bus_wdata_o = r_wdata;
  assign bus_err_o   = r_err;

  assign if_ack_o    = w_done && (r_owner == OWN_IF);
  assign mem_ack_o   = w_done && (r_owner == OWN_MEM);
  assign if_rdata_o  = r_if_rdata;
  assign mem_rdata_o = r_mem_rdata;
  assign if_stall_o  = if_req_i && !if_ack_o;
  assign mem_stall_o = mem_req_i && !mem_ack_o;

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios then randomized
// transfers scored against a transaction-level model of the arbiter.
module tb_mem_port_arb;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_rdata_o;
  logic          if_ack_o;
  logic          if_stall_o;
  logic          mem_req_i;
  logic          mem_we_i;
  logic [3:0]    mem_wsel_i;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_wdata_i;
  logic [DW-1:0] mem_rdata_o;
  logic          mem_ack_o;
  logic          mem_stall_o;
  logic          bus_req_o;
  logic          bus_we_o;
  logic [3:0]    bus_wsel_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic [DW-1:0] bus_rdata_i;
  logic          bus_ready_i;
  logic          bus_err_o;

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;

  logic [DW-1:0] exp_if_rd;
  logic [DW-1:0] exp_mem_rd;
  logic          exp_err;

  mem_port_arb #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO),
    .CNT_W   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ack_o    (if_ack_o),
    .if_stall_o  (if_stall_o),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_wsel_i  (mem_wsel_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_ack_o   (mem_ack_o),
    .mem_stall_o (mem_stall_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_wsel_o  (bus_wsel_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_rdata_i (bus_rdata_i),
    .bus_ready_i (bus_ready_i),
    .bus_err_o   (bus_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One granted transfer, from the cycle its request is visible in IDLE up to
  // the IDLE cycle after its ack. The memory answers in BUSY cycle index d;
  // if d reaches TO the watchdog ends it at index TO-1 with read data 0.
  task automatic run_xfer(input bit exp_mem, input logic [AW-1:0] a, input logic we,
                          input logic [3:0] ws, input logic [DW-1:0] wd, input int d,
                          input logic [DW-1:0] rd, input bit ready_in_done,
                          input bit perturb, output int ack_cyc, output int busy_n);
    int  k;
    bit  timed_out;
    int  last;
    timed_out = (d > TO - 1);
    last      = timed_out ? TO - 1 : d;
    ack_cyc   = -1;
    busy_n    = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus_req_o && k < 20);
    if (!bus_req_o) begin
      check("grant_wait", 0, 1);
      return;
    end
    for (int i = 0; i <= last; i++) begin
      if (i > 0) @(negedge clk);
      busy_n++;
      check("busy_req", bus_req_o, 1'b1);
      check("busy_addr", bus_addr_o, a);
      check("busy_we", bus_we_o, we);
      check("busy_wsel", bus_wsel_o, we ? ws : 4'b0000);
      if (we) check("busy_wdata", bus_wdata_o, wd);
      check("busy_if_stall", if_stall_o, if_req_i);
      check("busy_mem_stall", mem_stall_o, mem_req_i);
      check("busy_no_ack", {if_ack_o, mem_ack_o}, 2'b00);
      if (perturb) begin
        if (exp_mem) begin
          mem_addr_i  = ~a;
          mem_wdata_i = ~wd;
          mem_wsel_i  = ~ws;
        end else begin
          if_addr_i = ~a;
        end
      end
      bus_ready_i = (i == d);
      bus_rdata_i = (i == d) ? rd : DW'($urandom);
    end
    @(negedge clk);
    if (timed_out) exp_err = 1'b1;
    if (!exp_mem) exp_if_rd = timed_out ? '0 : rd;
    else if (!we) exp_mem_rd = timed_out ? '0 : rd;
    ack_cyc = cyc;
    check("done_ack", {if_ack_o, mem_ack_o}, exp_mem ? 2'b01 : 2'b10);
    check("done_bus_req", bus_req_o, 1'b0);
    check("done_if_rdata", if_rdata_o, exp_if_rd);
    check("done_mem_rdata", mem_rdata_o, exp_mem_rd);
    check("done_err", bus_err_o, exp_err);
    check("done_stall", exp_mem ? mem_stall_o : if_stall_o, 1'b0);
    if (exp_mem) begin
      mem_req_i = 1'b0;
      mem_we_i  = 1'b0;
    end else begin
      if_req_i = 1'b0;
    end
    bus_ready_i = ready_in_done;
    bus_rdata_i = ~rd;
    @(negedge clk);
    bus_ready_i = 1'b0;
    check("idle_no_ack", {if_ack_o, mem_ack_o}, 2'b00);
    check("idle_bus_req", bus_req_o, 1'b0);
    check("idle_if_rdata", if_rdata_o, exp_if_rd);
    check("idle_mem_rdata", mem_rdata_o, exp_mem_rd);
  endtask

  initial begin
    int            k0;
    int            ack_c;
    int            bn;
    int            pat;
    int            d1;
    int            d2;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic          we;
    logic [3:0]    ws;
    logic [AW-1:0] ma;
    logic [AW-1:0] ia;
    logic [DW-1:0] wd;

    rst_n       = 1'b0;
    if_req_i    = 1'b0;
    if_addr_i   = '0;
    mem_req_i   = 1'b0;
    mem_we_i    = 1'b0;
    mem_wsel_i  = '0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    bus_rdata_i = '0;
    bus_ready_i = 1'b0;
    exp_if_rd   = '0;
    exp_mem_rd  = '0;
    exp_err     = 1'b0;

    #12;
    check("rst_bus_req", bus_req_o, 1'b0);
    check("rst_acks", {if_ack_o, mem_ack_o}, 2'b00);
    check("rst_err", bus_err_o, 1'b0);
    check("rst_we_wsel", {bus_we_o, bus_wsel_o}, 5'b0);
    check("rst_addr", bus_addr_o, 0);
    check("rst_rdata", {if_rdata_o, mem_rdata_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // IF-only read, memory ready in the first BUSY cycle.
    k0 = cyc;
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0040;
    #1 check("if_stall_c0", if_stall_o, 1'b1);
    run_xfer(1'b0, 32'h40, 1'b0, 4'b0, '0, 0, 32'h0010_0093, 1'b0, 1'b0, ack_c, bn);
    check("if_ack_latency", ack_c - k0, 2);

    // Simultaneous requests: MEM first, IF afterwards.
    k0 = cyc;
    if_req_i   = 1'b1;
    if_addr_i  = 32'h0000_0044;
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h0000_1000;
    run_xfer(1'b1, 32'h1000, 1'b0, 4'b0, '0, 0, 32'h1234_5678, 1'b0, 1'b0, ack_c, bn);
    check("sim_mem_ack_cyc", ack_c - k0, 2);
    run_xfer(1'b0, 32'h44, 1'b0, 4'b0, '0, 0, 32'h0000_0013, 1'b0, 1'b0, ack_c, bn);
    check("sim_if_ack_cyc", ack_c - k0, 5);

    // Store with ready after three wait cycles, request fields changed mid-transfer.
    mem_req_i   = 1'b1;
    mem_we_i    = 1'b1;
    mem_wsel_i  = 4'b0011;
    mem_addr_i  = 32'h0000_2000;
    mem_wdata_i = 32'hAABB_CCDD;
    run_xfer(1'b1, 32'h2000, 1'b1, 4'b0011, 32'hAABB_CCDD, 3, 32'hFFFF_0000, 1'b0, 1'b1,
             ack_c, bn);
    check("store_busy_cycles", bn, 4);

    // Ready pulsed in IDLE and in DONE is ignored.
    bus_ready_i = 1'b1;
    bus_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_ready_i = 1'b0;
    check("idle_ready_ack", {if_ack_o, mem_ack_o}, 2'b00);
    check("idle_ready_rdata", {if_rdata_o, mem_rdata_o}, {exp_if_rd, exp_mem_rd});
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0050;
    run_xfer(1'b0, 32'h50, 1'b0, 4'b0, '0, 1, 32'h0badc0de, 1'b1, 1'b0, ack_c, bn);

    // Watchdog: memory never answers.
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0080;
    if_rdata_o_pre_check: check("wd_pre_rdata", if_rdata_o, 32'h0badc0de);
    run_xfer(1'b0, 32'h80, 1'b0, 4'b0, '0, 99, 32'h5555_5555, 1'b0, 1'b0, ack_c, bn);
    check("wd_busy_cycles", bn, TO);
    check("wd_rdata_zero", if_rdata_o, 0);
    repeat (10) @(negedge clk);
    check("wd_err_sticky", bus_err_o, 1'b1);

    // Reset in the middle of a transfer.
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_0100;
    @(negedge clk);
    check("rst_mid_busy", bus_req_o, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req", bus_req_o, 1'b0);
    check("rst_mid_ack", {if_ack_o, mem_ack_o}, 2'b00);
    check("rst_mid_err", bus_err_o, 1'b0);
    if_req_i = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    exp_err    = 1'b0;
    exp_if_rd  = '0;
    exp_mem_rd = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_after_quiet", {if_ack_o, mem_ack_o, bus_req_o, bus_err_o}, 4'b0);
    end
    check("rst_after_rdata", if_rdata_o, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      pat = $urandom_range(1, 3);
      we  = 1'($urandom);
      ws  = 4'($urandom);
      ma  = AW'($urandom);
      ia  = AW'($urandom);
      wd  = DW'($urandom);
      d1  = $urandom_range(0, 6);
      d2  = $urandom_range(0, 6);
      r1  = DW'($urandom);
      r2  = DW'($urandom);
      if (pat >= 2) begin
        mem_req_i   = 1'b1;
        mem_we_i    = we;
        mem_wsel_i  = ws;
        mem_addr_i  = ma;
        mem_wdata_i = wd;
      end
      if (pat != 2) begin
        if_req_i  = 1'b1;
        if_addr_i = ia;
      end
      if (pat >= 2)
        run_xfer(1'b1, ma, we, ws, wd, d1, r1, 1'($urandom), 1'($urandom), ack_c, bn);
      if (pat != 2)
        run_xfer(1'b0, ia, 1'b0, 4'b0, '0, d2, r2, 1'($urandom), 1'($urandom), ack_c, bn);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
